shared_port_sched: RTL and testbench
====================================

Name: shared_port_sched

Overview:
Weighted round-robin scheduler that shares one command port of a memory/peripheral among NUM_REQ requesters.
- Each requester posts a burst request (start address plus length) with a valid/ready handshake.
- The scheduler picks a winner using per-requester credit weights and locks the port for the whole burst.
- It then issues len+1 address beats downstream with a valid/ready handshake.
- It sits between the requester front-ends and the shared port.

Parameters:
NUM_REQ, 2, number of requesters; power of 2, >=2
WEIGHT_W, 3, width of each weight field
WEIGHTS, {3'd1,3'd1}, packed weights; field i = WEIGHTS[i*WEIGHT_W +: WEIGHT_W]; a weight of 0 is treated as 1
ADDR_W, 32, address width
LEN_W, 4, burst length field width; value = beats-1
ADDR_INC, 4, address increment per beat
TIMEOUT_CYC, 255, stall limit; used only with SCHED_TIMEOUT_EN

Ports:
clk_i  in  1  clock; all logic is on the rising edge
rst_ni  in  1  reset, synchronous, active-low
req_valid_i  in  NUM_REQ  per-requester burst request valid
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
req_addr_i  in  NUM_REQ*ADDR_W  packed start addresses; slice i belongs to requester i
req_len_i  in  NUM_REQ*LEN_W  packed burst lengths (beats-1)
mem_valid_o  out  1  downstream beat valid
mem_ready_i  in  1  downstream beat ready
mem_addr_o  out  ADDR_W  current beat address
mem_last_o  out  1  final beat of the burst
grant_o  out  NUM_REQ  one-hot owner of the port while in XFER; 0 otherwise
busy_o  out  1  high in XFER
timeout_o  out  1  one-cycle abort pulse (SCHED_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
Reset, while rst_ni is sampled low:
- State goes to IDLE, curr_ptr=0, credit_cnt=weight[0], beat_cnt=0.
- Outputs: req_ready_o=0 (combinationally gated by !rst_ni), mem_valid_o=0, mem_last_o=0, grant_o=0, busy_o=0, mem_addr_o=0, timeout_o=0.

FSM has two states, IDLE and XFER.

IDLE:
- Winner w = first i with req_valid_i[i]=1, searching curr_ptr, curr_ptr+1, ... modulo NUM_REQ.
- req_ready_o[w]=1 in the same cycle (combinational).
- At that edge: capture addr/len of w, grant_o <= onehot(w), beat_cnt <= 0, go to XFER.
- No valid requests: stay in IDLE; pointer and credit are unchanged.

Credit update at acceptance:
- w==curr_ptr and credit_cnt>1: credit_cnt-1; pointer holds.
- w==curr_ptr and credit_cnt<=1: curr_ptr <= w+1; credit <= weight[w+1].
- w!=curr_ptr, weight[w]>1: curr_ptr <= w; credit <= weight[w]-1.
- w!=curr_ptr, weight[w]<=1: curr_ptr <= w+1; credit <= weight[w+1].
- Pointer wrap is a bitwise mask with NUM_REQ-1.

XFER:
- mem_valid_o=1.
- mem_addr_o = captured_addr + beat_cnt*ADDR_INC, truncated modulo 2^ADDR_W.
- mem_last_o = (beat_cnt==captured_len).
- Once mem_valid_o is asserted, addr/last hold stable until mem_ready_i.
- On mem_valid_o & mem_ready_i: beat_cnt+1; if it was the last beat, go to IDLE, and grant_o and busy_o clear at that edge.
- req_ready_o=0 throughout XFER; new requests wait.

Latency and throughput:
- Accept edge to first mem_valid_o: 1 cycle.
- Minimum one IDLE bubble between bursts.
- Peak rate is one beat per cycle within a burst.

Boundary conditions:
- len=0: single beat with mem_last_o=1.
- len=2^LEN_W-1: 2^LEN_W beats.
- Requester drops valid after acceptance: no effect on the burst.
- Reset asserted mid-burst: burst abandoned; no further beats; state as at reset on the next edge.

Optional Feature:
SCHED_TIMEOUT_EN
- Defined:
  - A stall counter counts consecutive XFER cycles with mem_valid_o=1 & mem_ready_i=0.
  - On reaching TIMEOUT_CYC: abort the burst, go to IDLE, pulse timeout_o for 1 cycle, clear grant_o.
  - Credit state is unchanged by the abort.
  - The counter clears on any beat handshake or in IDLE.
- Undefined: no counter logic; timeout_o tied 0; a burst waits indefinitely.

Test Plan:
1. Reset with rst_ni=0 for 2 cycles while req_valid_i=2'b11 -> req_ready_o=0, mem_valid_o=0, grant_o=0; first accept after release goes to requester 0.
2. Single request, req0 addr=0x100, len=3, mem_ready_i=1 -> 4 beats at 0x100/0x104/0x108/0x10C; mem_last_o only on 0x10C; busy_o drops after the 4th beat.
3. WEIGHTS={3'd3,3'd1}, both requesting continuously with len=0 -> acceptance order 0,1,1,1,0,1,1,1... (req1 weight 3, req0 weight 1).
4. Backpressure: mem_ready_i low 5 cycles mid-burst -> mem_addr_o/mem_last_o stable; no beat skipped or repeated.
5. rst_ni=0 during beat 2 of a len=7 burst -> mem_valid_o=0 on the next cycle; pointer=0; the next accept starts a fresh burst.
6. With SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, hold mem_ready_i=0 -> timeout_o pulses after 8 stalled cycles; FSM returns to IDLE; the other requester is granted next if it is requesting.

Source files
------------

// File: rtl/shared_port_sched.sv
// shared_port_sched: weighted round-robin scheduler that hands one shared
// command port to NUM_REQ burst requesters. The port stays locked for a whole burst.
// Optional stall-abort logic is enabled by defining SCHED_TIMEOUT_EN.
module shared_port_sched #(
  parameter int NUM_REQ     = 2,
  parameter int WEIGHT_W    = 3,
  parameter logic [NUM_REQ*WEIGHT_W-1:0] WEIGHTS = {3'd1, 3'd1},
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 4,
  parameter int ADDR_INC    = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  output logic                      mem_valid_o,
  input  logic                      mem_ready_i,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic                      mem_last_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, XFER} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_t;

  state_t state_q, state_d;
  logic [PTR_W-1:0]    curr_ptr, ptr_d, win, win_nxt;
  logic [WEIGHT_W-1:0] credit_cnt, credit_d;
  logic [LEN_W-1:0]    beat_cnt;
  burst_t              cap_q;
  logic                found, accept, beat_hs, last, abort;
  logic [NUM_REQ-1:0][WEIGHT_W-1:0] wts;

  // A zero weight would starve a requester, so it counts as 1.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wt
    localparam logic [WEIGHT_W-1:0] RAW = WEIGHTS[g*WEIGHT_W +: WEIGHT_W];
    assign wts[g] = (RAW == '0) ? WEIGHT_W'(1) : RAW;
  end

  // Rotating priority search starting at curr_ptr; lowest offset wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[curr_ptr + PTR_W'(k)]) begin
        found = 1'b1;
        win   = curr_ptr + PTR_W'(k);
      end
    end
  end

  assign win_nxt = win + PTR_W'(1);

  // Credit bookkeeping applied when a request is accepted.
  always_comb begin
    ptr_d    = curr_ptr;
    credit_d = credit_cnt;
    if (win == curr_ptr) begin
      if (credit_cnt > WEIGHT_W'(1)) credit_d = credit_cnt - WEIGHT_W'(1);
      else begin
        ptr_d    = win_nxt;
        credit_d = wts[win_nxt];
      end
    end else if (wts[win] > WEIGHT_W'(1)) begin
      ptr_d    = win;
      credit_d = wts[win] - WEIGHT_W'(1);
    end else begin
      ptr_d    = win_nxt;
      credit_d = wts[win_nxt];
    end
  end

  assign accept      = (state_q == IDLE) && found && rst_ni;
  assign req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;
  assign beat_hs     = (state_q == XFER) && mem_ready_i;
  assign last        = (beat_cnt == cap_q.len);
  assign mem_valid_o = (state_q == XFER);
  assign busy_o      = (state_q == XFER);
  assign mem_last_o  = (state_q == XFER) && last;
  assign mem_addr_o  = (state_q == XFER) ?
                       cap_q.addr + ADDR_W'(beat_cnt) * ADDR_W'(ADDR_INC) : '0;

`ifdef SCHED_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
  logic [ST_W-1:0] stall_q;
  logic            timeout_q;

  assign abort     = (state_q == XFER) && !mem_ready_i && (stall_q == ST_W'(TIMEOUT_CYC - 1));
  assign timeout_o = timeout_q;

  // Count consecutive stalled beats; the abort edge also produces the pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || state_q != XFER || mem_ready_i || abort) stall_q <= '0;
    else                                                      stall_q <= stall_q + ST_W'(1);
    timeout_q <= rst_ni && abort;
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYC);
  assign abort      = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: lock on accept, release after the last beat or an abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = XFER;
      XFER:    if ((beat_hs && last) || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst capture, beat counting, grant and credit state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      curr_ptr   <= '0;
      credit_cnt <= wts[0];
      beat_cnt   <= '0;
      cap_q      <= '0;
      grant_o    <= '0;
    end else if (accept) begin
      cap_q.addr <= req_addr_i[win*ADDR_W +: ADDR_W];
      cap_q.len  <= req_len_i[win*LEN_W +: LEN_W];
      grant_o    <= NUM_REQ'(1) << win;
      beat_cnt   <= '0;
      curr_ptr   <= ptr_d;
      credit_cnt <= credit_d;
    end else if (beat_hs) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
      if (last) grant_o <= '0;
    end else if (abort) begin
      grant_o <= '0;
    end
  end
endmodule

// File: tb/tb_shared_port_sched.sv
// Directed bench for shared_port_sched (2 requesters, weights req0=1, req1=3).
module tb_shared_port_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic        mem_valid, mem_ready, mem_last, busy, timeout;
  logic [31:0] mem_addr;
  logic [1:0]  grant;
  int          n_chk = 0, n_pass = 0;

  shared_port_sched #(
    .NUM_REQ(2), .WEIGHT_W(3), .WEIGHTS({3'd3, 3'd1}), .ADDR_W(32), .LEN_W(4),
    .ADDR_INC(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len), .mem_valid_o(mem_valid),
    .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_last_o(mem_last),
    .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; mem_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; mem_ready = 1'b1;
    req_addr = {32'h0000_0300, 32'h0000_0200}; req_len = 8'h00;
    tick();
    n_chk++; if (req_ready !== 2'b00) $display("FAIL rst_ready got %b exp 00", req_ready); else n_pass++;
    tick();
    n_chk++; if ({mem_valid, busy, grant, mem_last, timeout} !== 6'b0)
      $display("FAIL rst_outs got %b exp 000000", {mem_valid, busy, grant, mem_last, timeout}); else n_pass++;
    n_chk++; if (mem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", mem_addr); else n_pass++;
    rst_n = 1'b1; #1;
    n_chk++; if (req_ready !== 2'b01) $display("FAIL rst_first_win got %b exp 01", req_ready); else n_pass++;
    tick();
    n_chk++; if ({grant, busy, mem_valid} !== 4'b0111)
      $display("FAIL rst_first_xfer got %b exp 0111", {grant, busy, mem_valid}); else n_pass++;
    n_chk++; if (mem_addr !== 32'h200) $display("FAIL rst_first_addr got %h exp 200", mem_addr); else n_pass++;
    req_valid = 2'b00;
    tick();
    n_chk++; if ({grant, busy} !== 3'b000) $display("FAIL rst_first_done got %b exp 000", {grant, busy}); else n_pass++;
  endtask

  task automatic test_single_burst();
    do_reset();
    req_valid = 2'b01; req_addr = {32'h0, 32'h0000_0100}; req_len = 8'h03; #1;
    n_chk++; if (req_ready !== 2'b01) $display("FAIL sb_ready got %b exp 01", req_ready); else n_pass++;
    tick();
    req_valid = 2'b00; req_addr = {32'h0, 32'hDEAD_0000}; req_len = 8'h00; // dropped after accept
    for (int i = 0; i < 4; i++) begin
      n_chk++; if ({mem_valid, mem_addr, mem_last} !== {1'b1, 32'h100 + 32'(4*i), i == 3})
        $display("FAIL sb_beat%0d got v=%b a=%h l=%b exp a=%h l=%b", i, mem_valid, mem_addr, mem_last,
                 32'h100 + 32'(4*i), i == 3); else n_pass++;
      tick();
    end
    n_chk++; if ({busy, mem_valid, grant} !== 4'b0) $display("FAIL sb_end got %b exp 0000", {busy, mem_valid, grant}); else n_pass++;
  endtask

  task automatic test_weighted_rr();
    logic [1:0] exp_w [8] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
    do_reset();
    req_valid = 2'b11; req_addr = {32'h0000_2000, 32'h0000_1000}; req_len = 8'h00; #1;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (req_ready !== exp_w[i]) $display("FAIL wrr_accept%0d got %b exp %b", i, req_ready, exp_w[i]); else n_pass++;
      tick();
      n_chk++; if ({mem_last, grant} !== {1'b1, exp_w[i]})
        $display("FAIL wrr_beat%0d got l=%b g=%b exp l=1 g=%b", i, mem_last, grant, exp_w[i]); else n_pass++;
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 2'b10; req_addr = {32'h0000_1000, 32'h0}; req_len = 8'h30; #1;
    n_chk++; if (req_ready !== 2'b10) $display("FAIL bp_ready got %b exp 10", req_ready); else n_pass++;
    tick();
    req_valid = 2'b00;
    n_chk++; if (mem_addr !== 32'h1000) $display("FAIL bp_beat0 got %h exp 1000", mem_addr); else n_pass++;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if ({mem_valid, mem_addr, mem_last} !== {1'b1, 32'h1004, 1'b0})
        $display("FAIL bp_hold%0d got v=%b a=%h l=%b exp v=1 a=1004 l=0", i, mem_valid, mem_addr, mem_last); else n_pass++;
      tick();
    end
    mem_ready = 1'b1;
    n_chk++; if (mem_addr !== 32'h1004) $display("FAIL bp_beat1 got %h exp 1004", mem_addr); else n_pass++;
    tick();
    n_chk++; if ({mem_addr, mem_last} !== {32'h1008, 1'b0}) $display("FAIL bp_beat2 got %h/%b exp 1008/0", mem_addr, mem_last); else n_pass++;
    tick();
    n_chk++; if ({mem_addr, mem_last} !== {32'h100C, 1'b1}) $display("FAIL bp_beat3 got %h/%b exp 100c/1", mem_addr, mem_last); else n_pass++;
    tick();
    n_chk++; if (busy !== 1'b0) $display("FAIL bp_end busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    // Move the pointer to 1 first so the post-reset win on 0 proves it was cleared.
    req_valid = 2'b01; req_addr = {32'h0, 32'h0000_0040}; req_len = 8'h07;
    tick();
    req_valid = 2'b00;
    tick(); tick();
    n_chk++; if (mem_addr !== 32'h48) $display("FAIL mr_beat2 got %h exp 48", mem_addr); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_chk++; if ({mem_valid, busy, grant} !== 4'b0) $display("FAIL mr_abandon got %b exp 0000", {mem_valid, busy, grant}); else n_pass++;
    rst_n = 1'b1; req_valid = 2'b11; req_addr = {32'h0000_0600, 32'h0000_0500}; req_len = 8'h00; #1;
    n_chk++; if (req_ready !== 2'b01) $display("FAIL mr_ptr got %b exp 01", req_ready); else n_pass++;
    tick();
    req_valid = 2'b00;
    n_chk++; if ({mem_addr, mem_last} !== {32'h500, 1'b1}) $display("FAIL mr_fresh got %h/%b exp 500/1", mem_addr, mem_last); else n_pass++;
    tick();
  endtask

  task automatic test_max_len_wrap();
    do_reset();
    req_valid = 2'b01; req_addr = {32'h0, 32'hFFFF_FFF8}; req_len = 8'h0F;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if ({mem_valid, mem_addr, mem_last} !== {1'b1, 32'hFFFF_FFF8 + 32'(4*i), i == 15})
        $display("FAIL ml_beat%0d got v=%b a=%h l=%b exp a=%h l=%b", i, mem_valid, mem_addr, mem_last,
                 32'hFFFF_FFF8 + 32'(4*i), i == 15); else n_pass++;
      tick();
    end
    n_chk++; if (busy !== 1'b0) $display("FAIL ml_end busy got %b exp 0", busy); else n_pass++;
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_valid = 2'b11; req_addr = {32'h0000_0900, 32'h0000_0800}; req_len = 8'h33; mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      n_chk++; if ({timeout, mem_valid} !== 2'b01) $display("FAIL to_stall%0d got %b exp 01", i, {timeout, mem_valid}); else n_pass++;
      tick();
    end
    tick();
    n_chk++; if ({timeout, busy, grant, req_ready} !== 6'b100010)
      $display("FAIL to_abort got %b exp 100010", {timeout, busy, grant, req_ready}); else n_pass++;
    tick();
    n_chk++; if ({timeout, busy, grant} !== 4'b0110) $display("FAIL to_next got %b exp 0110", {timeout, busy, grant}); else n_pass++;
    req_valid = 2'b00;
    do_reset();
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_len = '0; mem_ready = 1'b1;
    test_reset();
    test_single_burst();
    test_weighted_rr();
    test_backpressure();
    test_reset_mid_burst();
    test_max_len_wrap();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
